hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core.
- Drives the enable and flush (bubble) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and squashes wrong-path instructions on taken branches.
- Arbitrates the single external refill port between I-cache and D-cache misses, freezing the pipeline for the duration of each refill burst.

---
 rtl/core_pkg.sv | 16 +
 rtl/load_use_detect.sv | 20 ++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared pipeline-control types and constants.
// Used by the hazard sequencer and its helpers.
package core_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_IREF = 2'd1,
    ST_DREF = 2'd2
  } state_t;

  localparam logic MEM_SEL_I = 1'b0;
  localparam logic MEM_SEL_D = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: a load in EX feeds a source of the
// instruction in ID, so ID must wait one cycle.
module load_use_detect
  import core_pkg::*;
(
  input  logic       memread,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  output logic       hazard
);

  // x0 is never a real dependency.
  always_comb begin
    hazard = memread
           & (idex_rt != REG_ZERO)
           & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stalls, flushes and refill-port
// arbitration between I-cache and D-cache misses.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int REFILL_WORDS = 4,
  parameter int BEAT_W = $clog2(REFILL_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_hit,
  input  logic              dcache_req,
  input  logic              dcache_hit,
  input  logic              idex_memread,
  input  logic [4:0]        idex_rt,
  input  logic [4:0]        ifid_rs,
  input  logic [4:0]        ifid_rt,
  input  logic              branch_taken,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_sel,
  output logic              icache_fill,
  output logic              dcache_fill,
  output logic [BEAT_W-1:0] fill_idx,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_flush,
  output logic              idex_flush
);

  state_t            state;
  state_t            state_nxt;
  logic [BEAT_W-1:0] cnt;
  logic [BEAT_W-1:0] cnt_nxt;
  logic              sel_nxt;
  logic              dmiss;
  logic              imiss;
  logic              last;
  logic              lu_hazard;

  assign dmiss = dcache_req & ~dcache_hit;
  assign imiss = ~icache_hit;
  assign last  = (cnt == BEAT_W'(REFILL_WORDS - 1));

  load_use_detect u_lud (
    .memread (idex_memread),
    .idex_rt (idex_rt),
    .ifid_rs (ifid_rs),
    .ifid_rt (ifid_rt),
    .hazard  (lu_hazard)
  );

  // State, beat counter and refill owner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      cnt     <= '0;
      mem_sel <= MEM_SEL_I;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mem_sel <= sel_nxt;
    end
  end

  // Next state: D wins in RUN; a burst always runs to completion.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = mem_sel;
    unique case (state)
      ST_RUN: begin
        if (dmiss) begin
          state_nxt = ST_DREF;
          sel_nxt   = MEM_SEL_D;
        end else if (imiss) begin
          state_nxt = ST_IREF;
          sel_nxt   = MEM_SEL_I;
        end
      end
      ST_IREF, ST_DREF: begin
        if (mem_ack) begin
          if (last) begin
            cnt_nxt   = '0;
            state_nxt = ST_RUN;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Refill port strobes and the stall/flush priority mux.
  always_comb begin
    mem_req     = (state != ST_RUN);
    icache_fill = (state == ST_IREF) & mem_ack;
    dcache_fill = (state == ST_DREF) & mem_ack;
    fill_idx    = cnt;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (rst) begin
      mem_req     = 1'b0;
      icache_fill = 1'b0;
      dcache_fill = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if ((state == ST_DREF) | dmiss) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if ((state == ST_IREF) | imiss) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu_hazard) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl.
// Expected output vectors are queued as stimulus is driven.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       icache_hit;
  logic       dcache_req;
  logic       dcache_hit;
  logic       idex_memread;
  logic [4:0] idex_rt;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       branch_taken;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_sel;
  logic       icache_fill;
  logic       dcache_fill;
  logic [1:0] fill_idx;
  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  logic       ifid_flush;
  logic       idex_flush;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [12:0] exp;
    logic [12:0] mask;
  } sb_t;

  sb_t sbq[$];

  // {req,sel,ifill,dfill,idx[1:0],pc,ifid,idex,exmem,memwb,iflush,xflush}
  localparam logic [12:0] ALL   = 13'h1fff;
  localparam logic [12:0] NOIDX = 13'h1fff & ~13'h0180;
  localparam logic [6:0]  RUN   = 7'b11111_00;
  localparam logic [6:0]  IST   = 7'b00111_01;
  localparam logic [6:0]  FRZ   = 7'b00000_00;
  localparam logic [6:0]  FLU   = 7'b11111_11;

  hazard_ctrl #(.REFILL_WORDS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .icache_hit   (icache_hit),
    .dcache_req   (dcache_req),
    .dcache_hit   (dcache_hit),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .branch_taken (branch_taken),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_sel      (mem_sel),
    .icache_fill  (icache_fill),
    .dcache_fill  (dcache_fill),
    .fill_idx     (fill_idx),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] mk(
    input logic r, input logic s, input logic fi,
    input logic fd, input logic [1:0] ix, input logic [6:0] ef
  );
    return {r, s, fi, fd, ix, ef};
  endfunction

  // Queue the expectation, compare mid-cycle, advance one clock.
  task automatic step(
    input string t, input logic [12:0] e, input logic [12:0] m
  );
    sb_t cur;
    logic [12:0] obs;
    sbq.push_back('{tag: t, exp: e, mask: m});
    @(negedge clk);
    cur = sbq.pop_front();
    obs = {mem_req, mem_sel, icache_fill, dcache_fill, fill_idx,
           pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush};
    checks++;
    assert ((obs & cur.mask) === (cur.exp & cur.mask)) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b mask=%b",
             cur.tag, obs, cur.exp, cur.mask);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    icache_hit = 1'b1;
    dcache_req = 1'b0;
    dcache_hit = 1'b1;
    idex_memread = 1'b0;
    idex_rt = 5'd0;
    ifid_rs = 5'd0;
    ifid_rt = 5'd0;
    branch_taken = 1'b0;
    mem_ack = 1'b0;
    @(posedge clk);
    #1;
    step("reset", mk(0, 0, 0, 0, 0, FLU), NOIDX);
    rst = 1'b0;
    step("idle", mk(0, 0, 0, 0, 0, RUN), ALL);

    // Load-use via rs, then load gone, then rt=0, then via rt.
    idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    step("lu_rs", mk(0, 0, 0, 0, 0, IST), ALL);
    idex_memread = 1'b0;
    step("lu_clear", mk(0, 0, 0, 0, 0, RUN), ALL);
    idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
    step("lu_x0", mk(0, 0, 0, 0, 0, RUN), ALL);
    idex_rt = 5'd7; ifid_rt = 5'd7; ifid_rs = 5'd3;
    step("lu_rt", mk(0, 0, 0, 0, 0, IST), ALL);
    idex_rt = 5'd8;
    step("lu_nomatch", mk(0, 0, 0, 0, 0, RUN), ALL);
    idex_memread = 1'b0;

    // I-miss: one miss cycle, then four consecutive acks.
    icache_hit = 1'b0;
    step("imiss_run", mk(0, 0, 0, 0, 0, IST), ALL);
    icache_hit = 1'b1; mem_ack = 1'b1;
    for (int i = 0; i < 4; i++)
      step("ifill", mk(1, 0, 1, 0, 2'(i), IST), ALL);
    mem_ack = 1'b0;
    step("irun_back", mk(0, 0, 0, 0, 0, RUN), ALL);

    // Simultaneous I and D miss: D burst first, then I.
    icache_hit = 1'b0; dcache_req = 1'b1; dcache_hit = 1'b0;
    step("both_run", mk(0, 0, 0, 0, 0, FRZ), ALL);
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++)
      step("dfill_both", mk(1, 1, 0, 1, 2'(i), FRZ), ALL);
    mem_ack = 1'b0; dcache_hit = 1'b1;
    step("i_pending", mk(0, 1, 0, 0, 0, IST), ALL);
    icache_hit = 1'b1;
    step("iref_wait", mk(1, 0, 0, 0, 0, IST), ALL);
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++)
      step("ifill_after", mk(1, 0, 1, 0, 2'(i), IST), ALL);
    mem_ack = 1'b0; dcache_req = 1'b0;
    step("both_done", mk(0, 0, 0, 0, 0, RUN), ALL);

    // D-miss raised at beat 2 of an I burst.
    icache_hit = 1'b0;
    step("imiss2", mk(0, 0, 0, 0, 0, IST), ALL);
    icache_hit = 1'b1; mem_ack = 1'b1;
    step("ifill_b0", mk(1, 0, 1, 0, 0, IST), ALL);
    step("ifill_b1", mk(1, 0, 1, 0, 1, IST), ALL);
    dcache_req = 1'b1; dcache_hit = 1'b0;
    step("ifill_b2_frz", mk(1, 0, 1, 0, 2, FRZ), ALL);
    step("ifill_b3_frz", mk(1, 0, 1, 0, 3, FRZ), ALL);
    mem_ack = 1'b0;
    step("dmiss_run", mk(0, 0, 0, 0, 0, FRZ), ALL);
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++)
      step("dfill_late", mk(1, 1, 0, 1, 2'(i), FRZ), ALL);
    mem_ack = 1'b0; dcache_hit = 1'b1;
    step("d_done", mk(0, 1, 0, 0, 0, RUN), ALL);
    dcache_req = 1'b0;

    // Branch overrides load-use.
    idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    branch_taken = 1'b1;
    step("br_lu", mk(0, 1, 0, 0, 0, FLU), ALL);
    idex_memread = 1'b0;

    // Branch held through a D refill acts right after it.
    dcache_req = 1'b1; dcache_hit = 1'b0;
    step("br_dmiss", mk(0, 1, 0, 0, 0, FRZ), ALL);
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++)
      step("br_dfill", mk(1, 1, 0, 1, 2'(i), FRZ), ALL);
    mem_ack = 1'b0; dcache_hit = 1'b1;
    step("br_after", mk(0, 1, 0, 0, 0, FLU), ALL);
    branch_taken = 1'b0; dcache_req = 1'b0;
    step("br_clear", mk(0, 1, 0, 0, 0, RUN), ALL);

    // Reset at beat 1 abandons the burst; stray ack ignored.
    icache_hit = 1'b0;
    step("imiss3", mk(0, 1, 0, 0, 0, IST), ALL);
    icache_hit = 1'b1; mem_ack = 1'b1;
    step("ifill_r0", mk(1, 0, 1, 0, 0, IST), ALL);
    rst = 1'b1;
    step("rst_mid", mk(0, 0, 0, 0, 0, FLU), NOIDX);
    rst = 1'b0;
    step("stray_ack", mk(0, 0, 0, 0, 0, RUN), ALL);
    mem_ack = 1'b0;
    step("final_idle", mk(0, 0, 0, 0, 0, RUN), ALL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
